// File: rtl/raster_stream_tx_pkg.sv
// Shared video definitions: FSM state encoding, count width and default raster geometry.
package raster_stream_tx_pkg;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned CNT_LIMIT = 1 << CNT_W;

    localparam int unsigned DEF_ACTIVE_W = 320;
    localparam int unsigned DEF_ACTIVE_H = 240;
    localparam int unsigned DEF_HBLANK   = 16;
    localparam int unsigned DEF_VBLANK   = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StHblank = 2'd2,
        StVblank = 2'd3
    } state_e;

endpackage

// File: rtl/raster_stream_tx_if.sv
// Pixel input handshake plus raster output bundle; master is the transmitter side.
interface raster_stream_tx_if;
    import raster_stream_tx_pkg::*;

    logic       enable;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] dout;
    logic       validout;
    logic       blankingregion;
    cnt_t       rowcount;
    cnt_t       colcount;
    logic       frame_start;
    logic       underflow;

    modport master (
        input  enable, din, din_valid,
        output din_ready, dout, validout, blankingregion, rowcount, colcount,
               frame_start, underflow
    );

    modport slave (
        output enable, din, din_valid,
        input  din_ready, dout, validout, blankingregion, rowcount, colcount,
               frame_start, underflow
    );

endinterface

// File: rtl/raster_counter.sv
// Row/column position counter: column wraps at COL_MAX into a row step, row wraps at ROW_MAX.
module raster_counter
    import raster_stream_tx_pkg::*;
#(
    parameter int unsigned COL_MAX = 1,
    parameter int unsigned ROW_MAX = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_advance,
    output cnt_t o_row,
    output cnt_t o_col,
    output logic o_col_last,
    output logic o_row_last
);

    localparam cnt_t ColLast = cnt_t'(COL_MAX);
    localparam cnt_t RowLast = cnt_t'(ROW_MAX);

    cnt_t r_row;
    cnt_t r_col;

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_col_last = (r_col == ColLast);
    assign o_row_last = (r_row == RowLast);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (o_col_last) begin
                r_col <= '0;
                r_row <= o_row_last ? '0 : r_row + cnt_t'(1);
            end else begin
                r_col <= r_col + cnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/raster_stream_tx.sv
// Raster stream transmitter: paces upstream pixels into rows, inserts horizontal and vertical
// blanking, and reports the position of every registered output.
module raster_stream_tx
    import raster_stream_tx_pkg::*;
#(
    parameter int unsigned ACTIVE_W = DEF_ACTIVE_W,
    parameter int unsigned ACTIVE_H = DEF_ACTIVE_H,
    parameter int unsigned HBLANK   = DEF_HBLANK,
    parameter int unsigned VBLANK   = DEF_VBLANK
) (
    input logic               clock,
    input logic               reset,
    raster_stream_tx_if.master bus
);

    if (ACTIVE_W + HBLANK > CNT_LIMIT) begin : g_bad_width
        $error("ACTIVE_W + HBLANK exceeds the 10-bit column range");
    end
    if (ACTIVE_H + VBLANK > CNT_LIMIT) begin : g_bad_height
        $error("ACTIVE_H + VBLANK exceeds the 10-bit row range");
    end
    if (HBLANK < 1 || ACTIVE_W < 1 || ACTIVE_H < 1) begin : g_bad_geometry
        $error("ACTIVE_W, ACTIVE_H and HBLANK must be at least 1");
    end

    localparam cnt_t ColActLast = cnt_t'(ACTIVE_W - 1);
    localparam cnt_t RowActLast = cnt_t'(ACTIVE_H - 1);
    localparam bit   HasVblank  = (VBLANK > 0);

    state_e     r_state;
    state_e     w_state_d;
    cnt_t       w_row;
    cnt_t       w_col;
    logic       w_col_last;
    logic       w_row_last;
    logic       w_clear;
    logic       w_advance;
    logic       w_emit;
    logic       w_blank;
    logic       w_stall;
    state_e     w_frame_end;

    logic [7:0] r_dout;
    logic       r_validout;
    logic       r_blank;
    cnt_t       r_rowcount;
    cnt_t       r_colcount;
    logic       r_frame_start;
    logic       r_underflow;

    raster_counter #(
        .COL_MAX(ACTIVE_W + HBLANK - 1),
        .ROW_MAX(ACTIVE_H + VBLANK - 1)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_advance  (w_advance),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_col_last (w_col_last),
        .o_row_last (w_row_last)
    );

    // enable is only consulted here and in IDLE, so mid-frame drops let the frame finish
    assign w_frame_end = bus.enable ? StActive : StIdle;

    always_comb begin
        w_state_d = r_state;
        w_clear   = 1'b0;
        w_advance = 1'b0;
        w_emit    = 1'b0;
        w_blank   = 1'b0;
        w_stall   = 1'b0;
        case (r_state)
            StIdle: begin
                w_clear = 1'b1;
                if (bus.enable) begin
                    w_state_d = StActive;
                end
            end
            StActive: begin
                if (bus.din_valid) begin
                    w_advance = 1'b1;
                    w_emit    = 1'b1;
                    if (w_col == ColActLast) begin
                        w_state_d = StHblank;
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
            StHblank: begin
                w_advance = 1'b1;
                w_emit    = 1'b1;
                w_blank   = 1'b1;
                if (w_col_last) begin
                    if (w_row != RowActLast) begin
                        w_state_d = StActive;
                    end else if (HasVblank) begin
                        w_state_d = StVblank;
                    end else begin
                        w_state_d = w_frame_end;
                    end
                end
            end
            StVblank: begin
                w_advance = 1'b1;
                w_emit    = 1'b1;
                w_blank   = 1'b1;
                if (w_col_last && w_row_last) begin
                    w_state_d = w_frame_end;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Counts track the pending position every cycle, so a stall shows where output resumes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dout        <= '0;
            r_validout    <= 1'b0;
            r_blank       <= 1'b0;
            r_rowcount    <= '0;
            r_colcount    <= '0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_dout        <= (w_emit && !w_blank) ? bus.din : 8'h00;
            r_validout    <= w_emit;
            r_blank       <= w_emit && w_blank;
            r_rowcount    <= w_row;
            r_colcount    <= w_col;
            r_frame_start <= w_emit && !w_blank && (w_row == '0) && (w_col == '0);
            if (w_stall) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.din_ready      = (r_state == StActive);
    assign bus.dout           = r_dout;
    assign bus.validout       = r_validout;
    assign bus.blankingregion = r_blank;
    assign bus.rowcount       = r_rowcount;
    assign bus.colcount       = r_colcount;
    assign bus.frame_start    = r_frame_start;
    assign bus.underflow      = r_underflow;

endmodule

// File: doc/raster_stream_tx.md
RASTER_STREAM_TX -- requirements
Module: raster_stream_tx

Interface
REQ-001 Parameter ACTIVE_W, default 320, active pixels per row.
REQ-002 Parameter ACTIVE_H, default 240, active rows per frame.
REQ-003 Parameter HBLANK, default 16, blanking cycles appended to every row, minimum 1.
REQ-004 Parameter VBLANK, default 4, blanking rows appended to every frame, minimum 0.
REQ-005 Ports, one per line (name  direction  width  meaning):
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low.
- enable  in  1  start/continue frames.
- din  in  8  pixel from upstream buffer.
- din_valid  in  1  din holds a pixel.
- din_ready  out  1  pixel accepted this cycle.
- dout  out  8  pixel.
- validout  out  1  dout/blankingregion meaningful.
- blankingregion  out  1  cycle is blanking.
- rowcount  out  10  row index of current output.
- colcount  out  10  column index of current output.
- frame_start  out  1  one-cycle pulse on pixel (0,0).
- underflow  out  1  sticky starvation flag.

Function
REQ-006 States: IDLE, ACTIVE, HBLANK, VBLANK; state held in one registered encoding.
REQ-007 IDLE -> ACTIVE on enable=1, with row=0, col=0; otherwise the block stays in IDLE with validout=0.
REQ-008 Handshake: din_ready=1 only in ACTIVE; a transfer occurs when din_valid && din_ready.
REQ-009 ACTIVE transfer:
- next cycle dout=din, validout=1, blankingregion=0, counts = position of that pixel.
- latency exactly 1 clock.
REQ-010 ACTIVE stall: with din_valid=0, validout=0 next cycle, position unchanged, underflow set.
REQ-011 After the transfer at col=ACTIVE_W-1 -> HBLANK.
REQ-012 HBLANK: one output per clock, no input needed:
- validout=1, blankingregion=1, dout=0.
- col runs ACTIVE_W .. ACTIVE_W+HBLANK-1.
REQ-013 End of HBLANK:
- row<ACTIVE_H-1 -> ACTIVE, row+1, col=0.
- row=ACTIVE_H-1 and VBLANK>0 -> VBLANK, row=ACTIVE_H, col=0.
- row=ACTIVE_H-1 and VBLANK=0 -> frame end (REQ-015).
REQ-014 VBLANK: one output per clock:
- validout=1, blankingregion=1, dout=0.
- col runs 0..ACTIVE_W+HBLANK-1; row increments at col wrap.
- last row = ACTIVE_H+VBLANK-1.
REQ-015 Frame end (last blanking cycle):
- enable=1 -> ACTIVE, row=0, col=0.
- enable=0 -> IDLE.
REQ-016 enable deassert mid-frame: the current frame completes; enable is sampled only in IDLE and at frame end.
REQ-017 frame_start=1 in the same cycle as the output of pixel (0,0), otherwise 0.
REQ-018 underflow: set only by REQ-010, cleared only by reset.
REQ-019 Counts are unsigned 10-bit values; elaboration fails if ACTIVE_W+HBLANK>1024 or ACTIVE_H+VBLANK>1024.
REQ-020 All outputs registered except din_ready, which decodes from state only (no combinational din_valid->din_ready path).

Reset
REQ-021 Asynchronous assertion, synchronous release; takes effect mid-frame with no frame completion.
REQ-022 Reset values:
- state=IDLE.
- dout=0, validout=0, blankingregion=0.
- rowcount=0, colcount=0.
- frame_start=0, underflow=0.
- din_ready=0.

Structure
REQ-023 The shared video package holds the state typedef, the 10-bit count width constant and the default geometry constants (320, 240, 16, 4).
REQ-024 One sub-module, raster_counter, owns the row/col counters with wrap logic and advance/clear inputs; the FSM and output registers stay in raster_stream_tx.

Verification
Scenarios use ACTIVE_W=4, ACTIVE_H=2, HBLANK=2, VBLANK=1.
REQ-025 Continuous input, enable=1:
- sequence per row: 4 pixels, 2 blanks.
- 2 rows, then 1 VBLANK row of 6 blanks; period 18 cycles.
- frame_start every 18 cycles; underflow stays 0.
REQ-026 din_valid low for 3 cycles at row 0, col 2:
- 3 cycles validout=0 with counts held at (0,2).
- pixel (0,2) follows; underflow=1.
REQ-027 Pixel 0xA5 accepted at (1,3):
- next cycle dout=0xA5, rowcount=1, colcount=3, blankingregion=0.
- next cycle HBLANK col 4.
REQ-028 enable dropped at (0,1): the frame completes through VBLANK (row 2, col 5), then IDLE, validout=0, din_ready=0.
REQ-029 reset low during HBLANK: all outputs at REQ-022 values in the same cycle; after release with enable=1, the next pixel is (0,0) with frame_start=1.
REQ-030 VBLANK=0 build: row 1 HBLANK is followed directly by pixel (0,0); period 12 cycles.
